// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encoding and byte-lane helpers shared by the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  function automatic logic [3:0] be_from_size(logic [1:0] size, logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off :
           size == SZ_HALF ? 4'b0011 << off :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] word, logic [1:0] off, logic [1:0] size,
                                              logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    return size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: round-robin grant over N requesters; the pointer names the highest-priority requester.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr, nxt;

  // Scan downward so the requester closest to the pointer overwrites the others.
  always_comb begin
    gnt = '0;
    nxt = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req[PW'((int'(ptr) + k) % N)]) begin
        gnt = '0;
        gnt[PW'((int'(ptr) + k) % N)] = 1'b1;
        nxt = PW'((int'(ptr) + k + 1) % N);
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= nxt;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data-memory port with size/alignment/range
// checking, lane steering for stores and extended load data returned one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0][1:0] req_size,
  input  logic [NUM_REQ-1:0]      req_unsigned,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  input  logic [31:0]             mem_rdata
);

  localparam int          IW       = $clog2(NUM_REQ);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gi;
  logic               any, err, we, uns;
  logic [31:0]        addr, wdata;
  logic [1:0]         sz, off;
  logic [32:0]        last;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk,
    .rst_n,
    .req    (req_valid),
    .advance(any),
    .gnt
  );

  always_comb begin
    gi = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gi = IW'(i);
  end

  assign any       = |gnt;
  assign req_ready = gnt;
  assign addr      = req_addr[gi];
  assign wdata     = req_wdata[gi];
  assign we        = req_we[gi];
  assign sz        = req_size[gi];
  assign uns       = req_unsigned[gi];
  assign off       = addr[1:0];

  // One past the last byte touched; 33 bits so accesses near 2^32 cannot wrap into range.
  assign last = {1'b0, addr} + (sz == SZ_WORD ? 33'd4 : sz == SZ_HALF ? 33'd2 : 33'd1);
  assign err  = any & (sz == 2'b11 | (sz == SZ_HALF & off[0]) | (sz == SZ_WORD & |off) |
                       addr < BASE_ADDR | last > END_ADDR);

  assign mem_addr  = any ? {addr[31:2], 2'b00} : '0;
  assign mem_wdata = !any ? '0 : sz == SZ_BYTE ? {4{wdata[7:0]}} : sz == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign mem_we    = any & we & ~err;
  assign mem_be    = any & ~err ? be_from_size(sz, off) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= gnt;
      if (any) begin
        rsp_err   <= err;
        rsp_rdata <= err | we ? '0 : load_extend(mem_rdata, off, sz, uns);
      end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed traffic against a byte-level reference model.
module tb_dmem_arbiter;

  localparam int          N     = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIM   = BASE + 32'(DEPTH * 4);

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]       req_valid, req_ready, req_we, req_unsigned, rsp_valid;
  logic [N-1:0][31:0] req_addr, req_wdata;
  logic [N-1:0][1:0]  req_size;
  logic [31:0]        rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic               rsp_err, mem_we;
  logic [3:0]         mem_be;

  int checks = 0, errors = 0;

  logic [31:0] mem [DEPTH];
  logic [7:0]  rm  [DEPTH*4];

  int          m_ptr = 0;
  logic [N-1:0] m_pend = '0;
  logic [31:0] m_rd = '0;
  logic        m_er = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(N), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic hit(logic [31:0] a);
    return a >= BASE && a < LIM;
  endfunction

  function automatic logic [AW-1:0] widx(logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  assign mem_rdata = hit(mem_addr) ? mem[widx(mem_addr)] : 32'h0;

  always @(posedge clk)
    if (mem_we && hit(mem_addr))
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[widx(mem_addr)][8*b+:8] = mem_wdata[8*b+:8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: grant by scanning from the pointer, then apply the access to a byte array.
  task automatic model_cycle();
    int g, n, ofs;
    logic [31:0] a, ew, v;
    logic [3:0] be;
    logic [1:0] sz;
    logic e, we;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("rsp_rdata", rsp_rdata, m_rd);
    chk("rsp_err", 32'(rsp_err), 32'(m_er));
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    chk("req_ready", 32'(req_ready), g < 0 ? 32'h0 : 32'h1 << g);
    if (g < 0) begin
      chk("idle_mem_we", 32'(mem_we), 32'h0);
      chk("idle_mem_be", 32'(mem_be), 32'h0);
      chk("idle_mem_addr", mem_addr, 32'h0);
      m_pend = '0;
      return;
    end
    a   = req_addr[g];
    sz  = req_size[g];
    we  = req_we[g];
    n   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    ofs = int'(a[1:0]);
    e   = sz == 2'd3 || (ofs % n) != 0 || a < BASE || longint'(a) + n > longint'(LIM);
    be  = '0;
    if (!e) for (int b = 0; b < n; b++) be[ofs + b] = 1'b1;
    for (int l = 0; l < 4; l++) ew[8*l+:8] = req_wdata[g][8*(l % n)+:8];
    chk("mem_addr", mem_addr, a & ~32'h3);
    chk("mem_be", 32'(mem_be), 32'(be));
    chk("mem_we", 32'(mem_we), 32'(we & ~e));
    if (sz != 2'd3) chk("mem_wdata", mem_wdata, ew);
    v = '0;
    if (!e && we) for (int b = 0; b < n; b++) rm[a - BASE + 32'(b)] = req_wdata[g][8*b+:8];
    if (!e && !we) begin
      for (int b = 0; b < n; b++) v[8*b+:8] = rm[a - BASE + 32'(b)];
      if (!req_unsigned[g] && n < 4 && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b+:8] = 8'hFF;
    end
    m_rd   = v;
    m_er   = e;
    m_pend = '0;
    m_pend[g] = 1'b1;
    m_ptr  = (g + 1) % N;
  endtask

  always @(negedge clk)
    if (!rst_n) begin
      m_ptr = 0; m_pend = '0; m_rd = '0; m_er = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    end else model_cycle();

  task automatic put(int r, logic [31:0] a, logic we, logic [1:0] sz, logic u, logic [31:0] wd);
    req_valid[r] = 1'b1; req_addr[r] = a; req_we[r] = we;
    req_size[r] = sz; req_unsigned[r] = u; req_wdata[r] = wd;
  endtask

  task automatic go();
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(9);
    return s == 0 ? BASE - 32'd8 + 32'($urandom_range(11)) :
           s == 1 ? LIM - 32'd8 + 32'($urandom_range(11)) : BASE + 32'($urandom_range(31));
  endfunction

  logic [31:0] e_addr [6] = '{32'h1001, 32'h1002, 32'h0FFC, 32'h1FFE, 32'h1000, 32'h1FFC};
  logic        e_we   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  e_sz   [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
  logic        e_err  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int bad, s;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_we = '0; req_size = '0; req_unsigned = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) rm[4*i+b] = mem[i][8*b+:8];
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Word store then load back
    put(0, 32'h1000, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_be", 32'(mem_be), 32'hF);
    chk("t1_we", 32'(mem_we), 32'h1);
    go();
    put(0, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
    chk("t1_st_valid", 32'(rsp_valid), 32'h1);
    chk("t1_st_rdata", rsp_rdata, 32'h0);
    go();
    chk("t1_ld_valid", 32'(rsp_valid), 32'h1);
    chk("t1_ld_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_ld_err", 32'(rsp_err), 32'h0);
    // Byte store, signed and unsigned byte loads
    put(0, 32'h1003, 1'b1, 2'd0, 1'b0, 32'h80);
    @(negedge clk);
    chk("t2_be", 32'(mem_be), 32'h8);
    chk("t2_wdata", mem_wdata, 32'h80808080);
    go();
    put(0, 32'h1003, 1'b0, 2'd0, 1'b0, 32'h0);
    go();
    put(1, 32'h1003, 1'b0, 2'd0, 1'b1, 32'h0);
    chk("t2_signed", rsp_rdata, 32'hFFFFFF80);
    go();
    chk("t2_unsigned", rsp_rdata, 32'h00000080);
    chk("t2_valid1", 32'(rsp_valid), 32'h2);
    // Contention alternates
    for (int i = 0; i < 4; i++) begin
      put(0, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
      put(1, 32'h1004, 1'b0, 2'd2, 1'b0, 32'h0);
      @(negedge clk);
      chk("t3_grant", 32'(req_ready), i % 2 == 0 ? 32'h1 : 32'h2);
      go();
      chk("t3_rsp", 32'(rsp_valid), i % 2 == 0 ? 32'h1 : 32'h2);
    end
    // Rejected accesses plus the last legal word
    for (int i = 0; i < 6; i++) begin
      put(0, e_addr[i], e_we[i], e_sz[i], 1'b0, 32'hA5A5A5A5);
      @(negedge clk);
      chk("t4_ready", 32'(req_ready), 32'h1);
      chk("t4_we", 32'(mem_we), 32'(e_we[i] & ~e_err[i]));
      if (e_err[i]) chk("t4_be", 32'(mem_be), 32'h0);
      go();
      chk("t4_err", 32'(rsp_err), 32'(e_err[i]));
      if (e_err[i]) chk("t4_rdata", rsp_rdata, 32'h0);
    end
    // Half store into upper lanes
    put(0, 32'h1004, 1'b1, 2'd2, 1'b0, 32'h12345678);
    go();
    put(0, 32'h1006, 1'b1, 2'd1, 1'b0, 32'h0000BEEF);
    @(negedge clk);
    chk("t5_be", 32'(mem_be), 32'hC);
    chk("t5_wdata", mem_wdata, 32'hBEEFBEEF);
    go();
    put(0, 32'h1004, 1'b0, 2'd2, 1'b0, 32'h0);
    go();
    chk("t5_rdata", rsp_rdata, 32'hBEEF5678);
    // Reset lands on a pending load
    put(1, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
    go();
    put(0, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    chk("t6_dropped", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    put(0, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
    put(1, 32'h1004, 1'b0, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_first", 32'(req_ready), 32'h1);
    go();
    // Random traffic
    repeat (500) begin
      for (int r = 0; r < N; r++)
        if ($urandom_range(3) != 0) begin
          s = $urandom_range(9);
          put(r, rand_addr(), 1'($urandom_range(1)), s < 3 ? 2'd0 : s < 6 ? 2'd1 : s < 9 ? 2'd2 : 2'd3,
              1'($urandom_range(1)), $urandom);
        end
      go();
    end
    go();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 0; b < 4; b++) if (mem[i][8*b+:8] !== rm[4*i+b]) bad++;
    chk("mem_image", 32'(bad), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
